// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the memory stage (funct3 codes, state encoding, data word).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_f3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_f3_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: combinational load extraction/sign-extension and store lane replication/byte enables.
module mem_lane_fmt
    import cpu_types_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [1:0] lane_i,
    input  word_t      load_word_i,
    input  word_t      store_word_i,
    output word_t      load_fmt_o,
    output word_t      store_fmt_o,
    output logic [3:0] byteen_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b           = load_word_i[8*lane_i +: 8];
        h           = lane_i[1] ? load_word_i[31:16] : load_word_i[15:0];
        load_fmt_o  = (funct3_i == LB)  ? {{24{b[7]}}, b}  :
                      (funct3_i == LH)  ? {{16{h[15]}}, h} :
                      (funct3_i == LBU) ? {24'b0, b}       :
                      (funct3_i == LHU) ? {16'b0, h}       : load_word_i;
        store_fmt_o = (funct3_i == SB) ? {4{store_word_i[7:0]}}  :
                      (funct3_i == SH) ? {2{store_word_i[15:0]}} : store_word_i;
        byteen_o    = (funct3_i == SB) ? (4'b0001 << lane_i)            :
                      (funct3_i == SH) ? (lane_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data cache handshake, load/store formatting and pipeline stall.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dmemr_mem,
    input  logic              dmemw_mem,
    input  logic [2:0]        funct3_mem,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [DATA_W-1:0] dmemstore_mem,
    input  logic              pipe_advance,
    input  logic              flush,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic [3:0]        dmembyteen,
    output logic [DATA_W-1:0] loaddata,
    output logic              mem_stall,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              misalign
);

    mem_state_t        state_q, state_d;
    logic [DATA_W-1:0] loaddata_q, loaddata_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic              req, mis, access;
    word_t             load_fmt, store_fmt;
    logic [3:0]        byteen_raw;

    assign req = dmemr_mem | dmemw_mem;

`ifdef MEM_MISALIGN_TRAP_EN
    logic half_acc, word_acc, misalign_q, misalign_d;
    assign half_acc = (funct3_mem == 3'(LH)) || (dmemr_mem && funct3_mem == 3'(LHU));
    assign word_acc = funct3_mem == 3'(LW);
    assign mis      = req & ((half_acc & addr_mem[0]) | (word_acc & |addr_mem[1:0]));
`else
    assign mis = 1'b0;
`endif

    mem_lane_fmt u_fmt (
        .funct3_i    (funct3_mem),
        .lane_i      (addr_mem[1:0]),
        .load_word_i (dmemload),
        .store_word_i(dmemstore_mem),
        .load_fmt_o  (load_fmt),
        .store_fmt_o (store_fmt),
        .byteen_o    (byteen_raw)
    );

    // nRST gates the strobes so they fall with the reset, not at the next edge
    assign access     = nRST & req & !flush & !mis & (state_q != DONE);
    assign dmemREN    = access & dmemr_mem;
    assign dmemWEN    = access & dmemw_mem & !dmemr_mem;
    assign dmemaddr   = {addr_mem[ADDR_W-1:2], 2'b00};
    assign dmemstore  = store_fmt;
    assign dmembyteen = dmemWEN ? byteen_raw : 4'b0000;
    assign mem_stall  = nRST & req & !dhit & (state_q != DONE) & !flush;
    assign loaddata   = loaddata_q;
    assign stall_cycles = stall_cycles_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req && !flush) state_d = (mis || dhit) ? DONE : WAIT;
            WAIT:    state_d = (flush || !req) ? IDLE : dhit ? DONE : WAIT;
            DONE:    if (pipe_advance || flush) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        loaddata_d     = (dmemREN && dhit) ? load_fmt : loaddata_q;
        stall_cycles_d = (mem_stall && !(&stall_cycles_q)) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= IDLE;
            loaddata_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            loaddata_q     <= loaddata_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // flag is held only while DONE was reached through the trap path
    assign misalign_d = (state_d == DONE) & ((state_q == DONE) ? misalign_q : mis);
    assign misalign   = misalign_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemr_mem, dmemw_mem, pipe_advance, flush, dhit;
    logic [2:0]  funct3_mem;
    logic [31:0] addr_mem, dmemstore_mem, dmemload;
    logic        dmemREN, dmemWEN, mem_stall, misalign;
    logic [31:0] dmemaddr, dmemstore, loaddata;
    logic [3:0]  dmembyteen;
    logic [15:0] stall_cycles;

    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_stall = 0;
    int          wr_cnt = 0;
    logic [31:0] last_load = 32'h0;
    logic [31:0] exp_q[$];

    mem_access_unit dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .dmemr_mem    (dmemr_mem),
        .dmemw_mem    (dmemw_mem),
        .funct3_mem   (funct3_mem),
        .addr_mem     (addr_mem),
        .dmemstore_mem(dmemstore_mem),
        .pipe_advance (pipe_advance),
        .flush        (flush),
        .dhit         (dhit),
        .dmemload     (dmemload),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .dmemaddr     (dmemaddr),
        .dmemstore    (dmemstore),
        .dmembyteen   (dmembyteen),
        .loaddata     (loaddata),
        .mem_stall    (mem_stall),
        .stall_cycles (stall_cycles),
        .misalign     (misalign)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (dmemWEN) wr_cnt <= wr_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w,
                           input int waits, input logic both, input logic [31:0] exp);
        step();
        dmemr_mem = 1'b1; dmemw_mem = both; funct3_mem = f3; addr_mem = a; dmemload = w; dhit = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #2;
            chk("ld_ren_wait", 32'(dmemREN), 32'd1);
            chk("ld_stall_wait", 32'(mem_stall), 32'd1);
            exp_stall++;
            step();
        end
        dhit = 1'b1;
        #2;
        chk("ld_ren_hit", 32'(dmemREN), 32'd1);
        chk("ld_wen_hit", 32'(dmemWEN), 32'd0);
        chk("ld_addr", dmemaddr, {a[31:2], 2'b00});
        chk("ld_stall_hit", 32'(mem_stall), 32'd0);
        exp_q.push_back(exp);
        step();
        dhit = 1'b0;
        #2;
        chk("done_ren", 32'(dmemREN), 32'd0);
        chk("done_stall", 32'(mem_stall), 32'd0);
        chk("loaddata", loaddata, exp_q.pop_front());
        last_load = exp;
        chk("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
        pipe_advance = 1'b1;
        step();
        pipe_advance = 1'b0; dmemr_mem = 1'b0; dmemw_mem = 1'b0;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_st, input logic [3:0] exp_be);
        int wr0;
        step();
        dmemw_mem = 1'b1; dmemr_mem = 1'b0; funct3_mem = f3; addr_mem = a; dmemstore_mem = d; dhit = 1'b1;
        wr0 = wr_cnt;
        #2;
        chk("st_wen", 32'(dmemWEN), 32'd1);
        chk("st_ren", 32'(dmemREN), 32'd0);
        chk("st_data", dmemstore, exp_st);
        chk("st_byteen", 32'(dmembyteen), 32'(exp_be));
        chk("st_stall", 32'(mem_stall), 32'd0);
        chk("st_addr", dmemaddr, {a[31:2], 2'b00});
        step();
        dhit = 1'b0;
        repeat (2) begin
            #2;
            chk("st_done_wen", 32'(dmemWEN), 32'd0);
            chk("st_done_be", 32'(dmembyteen), 32'd0);
            chk("st_keeps_load", loaddata, last_load);
            step();
        end
        pipe_advance = 1'b1;
        step();
        pipe_advance = 1'b0; dmemw_mem = 1'b0;
        #2;
        chk("st_one_write", 32'(wr_cnt - wr0), 32'd1);
    endtask

    initial begin
        nRST = 1'b0; dmemr_mem = 1'b0; dmemw_mem = 1'b0; funct3_mem = 3'b010; addr_mem = '0;
        dmemstore_mem = '0; pipe_advance = 1'b0; flush = 1'b0; dhit = 1'b0; dmemload = '0;
        #2;
        chk("rst_ren", 32'(dmemREN), 32'd0);
        chk("rst_wen", 32'(dmemWEN), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_be", 32'(dmembyteen), 32'd0);
        chk("rst_load", loaddata, 32'd0);
        chk("rst_cnt", 32'(stall_cycles), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        step();
        nRST = 1'b1;

        do_load(3'b010, 32'h100, 32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF);
        do_load(3'b000, 32'h103, 32'h80FF1234, 0, 1'b0, 32'hFFFFFF80);
        do_load(3'b100, 32'h103, 32'h80FF1234, 1, 1'b0, 32'h00000080);
        do_load(3'b000, 32'h101, 32'h00007F00, 0, 1'b0, 32'h0000007F);
        do_load(3'b001, 32'h102, 32'h80FF1234, 2, 1'b0, 32'hFFFF80FF);
        do_load(3'b101, 32'h100, 32'h1234F00D, 0, 1'b0, 32'h0000F00D);
        do_load(3'b011, 32'h104, 32'h13579BDF, 0, 1'b0, 32'h13579BDF);
        do_load(3'b010, 32'h500, 32'hCAFEF00D, 0, 1'b1, 32'hCAFEF00D);

        do_store(3'b001, 32'h202, 32'h0000ABCD, 32'hABCDABCD, 4'b1100);
        do_store(3'b010, 32'h600, 32'h11223344, 32'h11223344, 4'b1111);
        do_store(3'b000, 32'h003, 32'h000000EE, 32'hEEEEEEEE, 4'b1000);

        // store stuck in WAIT, then flushed
        step();
        dmemw_mem = 1'b1; funct3_mem = 3'b000; addr_mem = 32'h301; dmemstore_mem = 32'h0000005A;
        #2;
        chk("fl_be", 32'(dmembyteen), 32'h2);
        chk("fl_data", dmemstore, 32'h5A5A5A5A);
        exp_stall++;
        step();
        #2;
        chk("fl_wait_wen", 32'(dmemWEN), 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_wen_drop", 32'(dmemWEN), 32'd0);
        chk("fl_stall", 32'(mem_stall), 32'd0);
        step();
        flush = 1'b0; dmemw_mem = 1'b0;
        #2;
        chk("fl_load_kept", loaddata, last_load);
        chk("fl_cnt", 32'(stall_cycles), 32'(exp_stall));

        // dhit with no request must be ignored
        dhit = 1'b1; dmemload = 32'hFFFFFFFF;
        #1;
        chk("idle_ren", 32'(dmemREN), 32'd0);
        step();
        dhit = 1'b0;
        #2;
        chk("idle_dhit_load", loaddata, last_load);

        // LW at 0x101
        step();
        dmemr_mem = 1'b1; funct3_mem = 3'b010; addr_mem = 32'h101; dmemload = 32'h0BADF00D;
`ifdef MEM_MISALIGN_TRAP_EN
        #2;
        chk("mis_ren", 32'(dmemREN), 32'd0);
        chk("mis_stall", 32'(mem_stall), 32'd1);
        exp_stall++;
        step();
        #2;
        chk("mis_flag", 32'(misalign), 32'd1);
        chk("mis_load_kept", loaddata, last_load);
        chk("mis_done_ren", 32'(dmemREN), 32'd0);
        pipe_advance = 1'b1;
        step();
        pipe_advance = 1'b0; dmemr_mem = 1'b0;
        #2;
        chk("mis_clear", 32'(misalign), 32'd0);
`else
        dhit = 1'b1;
        #2;
        chk("unal_ren", 32'(dmemREN), 32'd1);
        chk("unal_addr", dmemaddr, 32'h100);
        chk("unal_mis", 32'(misalign), 32'd0);
        exp_q.push_back(32'h0BADF00D);
        step();
        dhit = 1'b0;
        #2;
        chk("unal_load", loaddata, exp_q.pop_front());
        last_load = 32'h0BADF00D;
        pipe_advance = 1'b1;
        step();
        pipe_advance = 1'b0; dmemr_mem = 1'b0;
`endif
        #1;
        chk("mis_cnt", 32'(stall_cycles), 32'(exp_stall));

        // asynchronous reset while waiting
        step();
        dmemr_mem = 1'b1; funct3_mem = 3'b010; addr_mem = 32'h400;
        step();
        #2;
        chk("ar_wait_ren", 32'(dmemREN), 32'd1);
        nRST = 1'b0;
        #1;
        chk("ar_ren", 32'(dmemREN), 32'd0);
        chk("ar_stall", 32'(mem_stall), 32'd0);
        chk("ar_cnt", 32'(stall_cycles), 32'd0);
        chk("ar_load", loaddata, 32'd0);
        step();
        dmemr_mem = 1'b0; nRST = 1'b1;
        exp_stall = 0; last_load = 32'h0;
        do_load(3'b010, 32'h404, 32'h600DCAFE, 0, 1'b0, 32'h600DCAFE);

        // long stall drives the counter into saturation
        step();
        dmemr_mem = 1'b1; funct3_mem = 3'b010; addr_mem = 32'h700; dmemload = 32'h76543210;
        repeat (65534) step();
        #1;
        chk("sat_near", 32'(stall_cycles), 32'h0000FFFE);
        repeat (3) step();
        #1;
        chk("sat_max", 32'(stall_cycles), 32'h0000FFFF);
        dhit = 1'b1;
        exp_q.push_back(32'h76543210);
        step();
        dhit = 1'b0;
        #2;
        chk("sat_load", loaddata, exp_q.pop_front());
        chk("sat_hold", 32'(stall_cycles), 32'h0000FFFF);
        pipe_advance = 1'b1;
        step();
        pipe_advance = 1'b0; dmemr_mem = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage access controller directly downstream of the EX/MEM pipeline register.
- Consumes the latched MEM-stage controls (read/write strobes, ALU address, store data, funct3). Runs the request/hit handshake with the data cache.
- Formats load data (byte/half/word, signed/unsigned) and store data with byte enables.
- Produces a stall to hold the pipeline, and a held, formatted load result for the MEM/WB register.

Parameters:
- ADDR_W, 32, data address width
- DATA_W, 32, data word width (fixed 32; byte-lane logic assumes 4 lanes)
- CNT_W, 16, width of saturating stall-cycle counter

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- dmemr_mem  in  1  load request from EX/MEM
- dmemw_mem  in  1  store request from EX/MEM
- funct3_mem  in  3  load/store size/sign code
- addr_mem  in  ADDR_W  effective address (presult_mem)
- dmemstore_mem  in  DATA_W  raw rs2 store data
- pipe_advance  in  1  pipeline control: all stages advancing this cycle
- flush  in  1  kill MEM-stage instruction
- dhit  in  1  cache access complete
- dmemload  in  DATA_W  cache read data (full word)
- dmemREN  out  1  cache read enable
- dmemWEN  out  1  cache write enable
- dmemaddr  out  ADDR_W  word-aligned address ({addr_mem[31:2],2'b00})
- dmemstore  out  DATA_W  lane-replicated store data
- dmembyteen  out  4  store byte enables
- loaddata  out  DATA_W  formatted load result, held
- mem_stall  out  1  MEM stage not finished; freeze upstream
- stall_cycles  out  CNT_W  saturating count of cycles mem_stall was high
- misalign  out  1  misaligned access flag (feature only; else tied 0)

Behaviour:
- Reset (async, nRST low): state IDLE, loaddata 0, stall_cycles 0, misalign 0. dmemREN, dmemWEN, mem_stall and dmembyteen are 0 as a consequence.
- req = dmemr_mem | dmemw_mem. If both are high, treat as a load and set dmemWEN = 0.
- States are IDLE, WAIT and DONE.
- IDLE:
  - If req & !flush: drive REN/WEN combinationally in the same cycle (zero-bubble).
  - If dhit is in the same cycle: capture loaddata; go to DONE.
  - If no dhit: go to WAIT.
- WAIT:
  - Keep REN/WEN asserted.
  - On dhit: capture loaddata, go to DONE.
  - On flush: drop the request, go to IDLE, loaddata unchanged.
- DONE:
  - REN/WEN are forced 0 even though EX/MEM may still hold the strobes. This guarantees one store per instruction.
  - Stay in DONE until pipe_advance or flush, then go to IDLE.
- mem_stall = req & !dhit & state != DONE & !flush.
- Load formatting, captured on the dhit edge (lane = addr_mem[1:0]):
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the half selected by addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend the selected byte.
  - 101 LHU: zero-extend the selected half.
  - Other codes: full word.
- Store formatting:
  - SB: data[7:0] replicated ×4, byteen = 1<<addr[1:0].
  - SH: data[15:0] replicated ×2, byteen = addr[1] ? 1100 : 0011.
  - SW and other codes: data as-is, byteen = 1111.
  - byteen = 0 when dmemWEN = 0.
- loaddata holds its value until the next captured load; stores do not modify it.
- stall_cycles increments each cycle mem_stall = 1 and saturates at all-ones (no wrap).
- dhit while not requesting (IDLE, req = 0) is ignored.
- nRST low mid-WAIT: abort immediately; REN/WEN drop asynchronously with the reset.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Accesses with LH/LHU/SH and addr[0] = 1, or LW/SW and addr[1:0] != 0, are misaligned.
  - A misaligned access never raises REN/WEN and goes directly IDLE->DONE.
  - misalign is registered 1 in DONE; loaddata is unchanged.
  - misalign clears on leaving DONE.
- Undefined:
  - misalign is tied 0.
  - Low address bits are ignored for word access.
  - Half access uses addr[1] only.

Decomposition:
- Shared package (cpu_types_pkg): funct3 load/store enum (LB, LH, LW, LBU, LHU, SB, SH, SW), mem_state_t enum {IDLE, WAIT, DONE}, word_t.
- One natural sub-module: mem_lane_fmt. It is purely combinational load extraction/sign-extension and store replication/byteen generation, unit-testable on its own.

Test Plan:
- LW to 0x100, dhit after 3 cycles, dmemload 0xDEADBEEF -> mem_stall high 3 cycles; loaddata 0xDEADBEEF; stall_cycles 3; REN low in DONE.
- LB at 0x103 with dmemload 0x80FF_1234 -> loaddata 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x202, data 0x0000ABCD, dhit same cycle -> dmemstore 0xABCDABCD, byteen 1100, mem_stall 0. DONE holds WEN=0 for 2 cycles while pipe_advance = 0 -> exactly one write.
- Store in WAIT, flush asserted -> WEN drops the same cycle, state IDLE, loaddata unchanged.
- Async reset mid-WAIT -> REN 0 immediately, stall_cycles 0, state IDLE. Force stall_cycles near 0xFFFF with a long stall -> it saturates at 0xFFFF.
- MEM_MISALIGN_TRAP_EN: LW at 0x101 -> no REN, misalign 1 in DONE, cleared after pipe_advance. Without the macro: the same access reads word 0x100.
